// File: rtl/queue.sv
// Register-based queue with random-access removal: per-slot pop mask, order-preserving
// compaction toward slot 0, and a single tail push per cycle. All slots are visible in parallel.
module queue #(
    parameter int  Size = 4,
    parameter type T    = logic [7:0]
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop  [Size],
    output logic [$clog2(Size+1)-1:0]  o_size,
    output T                           o_data [Size]
);

    localparam int SW = $clog2(Size + 1);

    logic [SW-1:0] size_p0;
    T              slot_p0  [Size];

    logic          survive  [Size];
    logic [SW-1:0] dest     [Size];
    logic [SW-1:0] n_keep;
    logic [SW-1:0] nxt_size;
    T              nxt_slot [Size];

    // Prefix count of survivors: dest[k] is the slot that surviving entry k compacts into.
    always_comb begin
        n_keep = '0;
        for (int k = 0; k < Size; k++) begin
            survive[k] = (SW'(k) < size_p0) && !i_pop[k];
            dest[k]    = n_keep;
            if (survive[k]) begin
                n_keep = n_keep + SW'(1);
            end
        end
    end

    // One mux per destination slot; the pushed entry lands right after the survivors.
    // Slots past the new size fall through to zero, which clears anything vacated.
    always_comb begin
        for (int d = 0; d < Size; d++) begin
            nxt_slot[d] = '0;
            for (int k = 0; k < Size; k++) begin
                if (survive[k] && (dest[k] == SW'(d))) begin
                    nxt_slot[d] = slot_p0[k];
                end
            end
            if (i_push && (n_keep == SW'(d))) begin
                nxt_slot[d] = i_data;
            end
        end
        nxt_size = n_keep;
        if (i_push && (n_keep < SW'(Size))) begin
            nxt_size = n_keep + SW'(1);
        end
    end

    // Register stage: every output comes straight from these flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            size_p0 <= '0;
            for (int k = 0; k < Size; k++) begin
                slot_p0[k] <= '0;
            end
        end else begin
            size_p0 <= nxt_size;
            for (int k = 0; k < Size; k++) begin
                slot_p0[k] <= nxt_slot[k];
            end
        end
    end

    assign o_size = size_p0;

    always_comb begin
        for (int k = 0; k < Size; k++) begin
            o_data[k] = slot_p0[k];
        end
    end

endmodule

// File: tb/tb_queue.sv
// Self-checking bench for queue: directed scenarios with literal expectations,
// then randomized push/pop traffic against a list-based reference model.
module tb_queue;

    localparam int Size = 4;
    typedef logic [7:0] T;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       push = 1'b0;
    T           data = '0;
    logic       pop  [Size];
    logic [2:0] size;
    T           dout [Size];

    int n_cmp = 0;
    int n_bad = 0;
    T   mq[$];

    always #5 clk = ~clk;

    queue #(.Size(Size), .T(T)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_push (push),
        .i_data (data),
        .i_pop  (pop),
        .o_size (size),
        .o_data (dout)
    );

    task automatic drive(input logic p, input T d, input logic [Size-1:0] m);
        push = p;
        data = d;
        for (int k = 0; k < Size; k++) pop[k] = m[k];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: keep entries not selected for removal (in order), then append if room.
    task automatic model_step();
        T nq[$];
        nq = {};
        for (int k = 0; k < mq.size(); k++) begin
            if (!pop[k]) nq.push_back(mq[k]);
        end
        if (push && nq.size() < Size) nq.push_back(data);
        mq = nq;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'd0, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mq = {};
    endtask

    task automatic test_reset();
        drive(1'b1, 8'h55, 4'b1111);
        rst = 1'b1;
        tick();
        n_cmp++;
        if (size !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_size: got %0d expected 0", size);
        end
        for (int k = 0; k < Size; k++) begin
            n_cmp++;
            if (dout[k] !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_data[%0d]: got %0d expected 0", k, dout[k]);
            end
        end
        rst = 1'b0;
        drive(1'b0, 8'd0, 4'b1111);
        tick();
        n_cmp++;
        if (size !== 3'd0) begin
            n_bad++;
            $display("FAIL pop_empty_size: got %0d expected 0", size);
        end
    endtask

    task automatic test_fill();
        T exp2 [Size] = '{8'd0, 8'd2, 8'd0, 8'd0};
        T exp4 [Size] = '{8'd0, 8'd2, 8'd4, 8'd6};
        do_reset();
        drive(1'b1, 8'd0, 4'b0000); tick();
        drive(1'b1, 8'd2, 4'b0000); tick();
        drive(1'b0, 8'd0, 4'b0000);
        n_cmp++;
        if (size !== 3'd2) begin
            n_bad++;
            $display("FAIL fill2_size: got %0d expected 2", size);
        end
        for (int k = 0; k < Size; k++) begin
            n_cmp++;
            if (dout[k] !== exp2[k]) begin
                n_bad++;
                $display("FAIL fill2_data[%0d]: got %0d expected %0d", k, dout[k], exp2[k]);
            end
        end
        drive(1'b1, 8'd4, 4'b0000); tick();
        drive(1'b1, 8'd6, 4'b0000); tick();
        drive(1'b1, 8'd9, 4'b0000); tick();
        drive(1'b0, 8'd0, 4'b0000);
        n_cmp++;
        if (size !== 3'd4) begin
            n_bad++;
            $display("FAIL full_drop_size: got %0d expected 4", size);
        end
        for (int k = 0; k < Size; k++) begin
            n_cmp++;
            if (dout[k] !== exp4[k]) begin
                n_bad++;
                $display("FAIL full_drop_data[%0d]: got %0d expected %0d", k, dout[k], exp4[k]);
            end
        end
    endtask

    task automatic test_pop_compact();
        T exp [Size] = '{8'd2, 8'd6, 8'd0, 8'd0};
        drive(1'b0, 8'd0, 4'b0101);
        tick();
        drive(1'b0, 8'd0, 4'b0000);
        n_cmp++;
        if (size !== 3'd2) begin
            n_bad++;
            $display("FAIL compact_size: got %0d expected 2", size);
        end
        for (int k = 0; k < Size; k++) begin
            n_cmp++;
            if (dout[k] !== exp[k]) begin
                n_bad++;
                $display("FAIL compact_data[%0d]: got %0d expected %0d", k, dout[k], exp[k]);
            end
        end
    endtask

    task automatic test_push_on_full();
        T exp1 [Size] = '{8'd0, 8'd4, 8'd6, 8'd7};
        T exp2 [Size] = '{8'd3, 8'd0, 8'd0, 8'd0};
        do_reset();
        for (int i = 0; i < Size; i++) begin
            drive(1'b1, T'(2 * i), 4'b0000);
            tick();
        end
        drive(1'b1, 8'd7, 4'b0010);
        tick();
        n_cmp++;
        if (size !== 3'd4) begin
            n_bad++;
            $display("FAIL full_swap_size: got %0d expected 4", size);
        end
        for (int k = 0; k < Size; k++) begin
            n_cmp++;
            if (dout[k] !== exp1[k]) begin
                n_bad++;
                $display("FAIL full_swap_data[%0d]: got %0d expected %0d", k, dout[k], exp1[k]);
            end
        end
        drive(1'b1, 8'd3, 4'b1111);
        tick();
        drive(1'b0, 8'd0, 4'b0000);
        n_cmp++;
        if (size !== 3'd1) begin
            n_bad++;
            $display("FAIL popall_push_size: got %0d expected 1", size);
        end
        for (int k = 0; k < Size; k++) begin
            n_cmp++;
            if (dout[k] !== exp2[k]) begin
                n_bad++;
                $display("FAIL popall_push_data[%0d]: got %0d expected %0d", k, dout[k], exp2[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, T'(8'hA0 + i), 4'b0000);
            tick();
        end
        drive(1'b0, 8'd0, 4'b0000);
        n_cmp++;
        if (size !== 3'd3) begin
            n_bad++;
            $display("FAIL async_pre_size: got %0d expected 3", size);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (size !== 3'd0) begin
            n_bad++;
            $display("FAIL async_size: got %0d expected 0", size);
        end
        for (int k = 0; k < Size; k++) begin
            n_cmp++;
            if (dout[k] !== 8'd0) begin
                n_bad++;
                $display("FAIL async_data[%0d]: got %0d expected 0", k, dout[k]);
            end
        end
        #1;
        rst = 1'b0;
        tick();
        n_cmp++;
        if (size !== 3'd0) begin
            n_bad++;
            $display("FAIL async_idle_size: got %0d expected 0", size);
        end
    endtask

    task automatic test_random();
        logic [Size-1:0] m;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            m = Size'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) m = '1;
            drive(($urandom_range(0, 9) < 7), T'($urandom), m);
            model_step();
            tick();
            n_cmp++;
            if (int'(size) !== mq.size()) begin
                n_bad++;
                $display("FAIL rand_size(iter %0d): got %0d expected %0d", i, size, mq.size());
            end
            for (int k = 0; k < Size; k++) begin
                T e;
                e = (k < mq.size()) ? mq[k] : '0;
                n_cmp++;
                if (dout[k] !== e) begin
                    n_bad++;
                    $display("FAIL rand_data[%0d](iter %0d): got %0d expected %0d", k, i, dout[k], e);
                end
            end
        end
        drive(1'b0, 8'd0, 4'b0000);
    endtask

    initial begin
        drive(1'b0, 8'd0, 4'b0000);
        test_reset();
        test_fill();
        test_pop_compact();
        test_push_on_full();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
